// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused over WIDTH cycles, LSB first.
// Optional feature macro SERIAL_ADDER_SUB_EN adds the in_sub port for subtraction.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends combinationally on ready, and outputs stay stable while valid waits.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             cell_sum;
    logic             cell_c;
    logic             accept;
    logic             step;
    logic             last_step;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and force the carry-in to 1.
    assign b_load = in_sub ? ~in_b : in_b;
    assign c_load = in_sub ? 1'b1 : in_c;
`else
    assign b_load = in_b;
    assign c_load = in_c;
`endif

    full_adder u_cell (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q),
        .sum   (cell_sum),
        .c_out (cell_c)
    );

    // The A register doubles as the result register: sum bits enter at the MSB
    // while operand bits leave at the LSB, so after WIDTH steps it holds the sum.
    generate
        if (WIDTH == 1) begin : g_single
            assign a_next = cell_sum;
        end else begin : g_multi
            assign a_next = {cell_sum, a_q[WIDTH-1:1]};
        end
    endgenerate

    assign accept    = (state == IDLE) && in_valid;
    assign step      = (state == SHIFT);
    assign last_step = step && (cnt_q == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_next;
            b_q     <= b_q >> 1;
            carry_q <= cell_c;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Separate result registers keep out_sum/out_c at 0 until the first result
    // and hold each result stable while the next operation shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
        end else if (last_step) begin
            sum_q <= a_next;
            c_q   <= cell_c;
        end
    end

    assign out_sum = sum_q;
    assign out_c   = c_q;

endmodule
